// File: rtl/fixed_pkg.sv
// Shared fixed-point arithmetic definitions: common FSM states and default
// Q-format dimensions used by the multiplier and divider.
package fixed_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_FRAC  = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULTIPLY = 2'd1,
        ROUND    = 2'd2
    } fixed_state_e;

endpackage

// File: rtl/fixed_multiplier.sv
// Signed Q(WIDTH-FRAC).FRAC multiplier: radix-2 shift-and-add on operand
// magnitudes over WIDTH cycles, then one cycle of round-half-up and saturation.
module fixed_multiplier
    import fixed_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int FRAC  = DEFAULT_FRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] product,
    output logic             overflow,
    output logic             finished,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int MW = 2 * WIDTH - FRAC + 1;
    localparam int RB = (FRAC > 0) ? FRAC - 1 : 0;
    localparam logic [MW-1:0] POS_LIMIT = (MW'(1) << (WIDTH - 1)) - MW'(1);
    localparam logic [MW-1:0] NEG_LIMIT = MW'(1) << (WIDTH - 1);

    fixed_state_e       state, next_state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand_sh;
    logic [WIDTH-1:0]   mplier_sh;
    logic [CW-1:0]      count;
    logic               neg;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               round_bit;
    logic [MW-1:0]      mag_full;
    logic [WIDTH-1:0]   prod_mag, prod_next;
    logic               ovf_next;

    // Unsigned magnitudes: -2^(WIDTH-1) negates to itself, which read as
    // unsigned is exactly 2^(WIDTH-1).
    assign a_mag = multiplicand[WIDTH-1] ? -multiplicand : multiplicand;
    assign b_mag = multiplier[WIDTH-1]   ? -multiplier   : multiplier;

    assign finished = (state == IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        // NOTE: default first so no path leaves next_state unassigned (no latch).
        next_state = state;
        case (state)
            IDLE:     if (start) next_state = MULTIPLY;
            MULTIPLY: if (count == '0) next_state = ROUND;
            ROUND:    next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        round_bit = (FRAC > 0) ? acc[RB] : 1'b0;
        mag_full  = MW'(acc >> FRAC) + MW'(round_bit);
        prod_mag  = mag_full[WIDTH-1:0];
        ovf_next  = 1'b0;
        if (!neg && mag_full > POS_LIMIT) begin
            prod_mag = POS_LIMIT[WIDTH-1:0];
            ovf_next = 1'b1;
        end else if (neg && mag_full > NEG_LIMIT) begin
            prod_mag = NEG_LIMIT[WIDTH-1:0];
            ovf_next = 1'b1;
        end
        // Negating zero yields zero, so a negative-signed zero stays 0.
        prod_next = neg ? -prod_mag : prod_mag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            mcand_sh  <= '0;
            mplier_sh <= '0;
            count     <= '0;
            neg       <= 1'b0;
            product   <= '0;
            overflow  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand_sh  <= {{WIDTH{1'b0}}, a_mag};
                        mplier_sh <= b_mag;
                        neg       <= multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
                        acc       <= '0;
                        count     <= CW'(WIDTH - 1);
                    end
                end
                MULTIPLY: begin
                    if (mplier_sh[0]) acc <= acc + mcand_sh;
                    mcand_sh  <= mcand_sh << 1;
                    mplier_sh <= mplier_sh >> 1;
                    count     <= count - CW'(1);
                end
                ROUND: begin
                    product  <= prod_next;
                    overflow <= ovf_next;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
